// File: rtl/wavetable_arbiter_if.sv
// Pipeline and ROM side signals of the wavetable arbiter.
// slave: arbiter view; master: pipelines plus ROM view.
interface wavetable_arbiter_if #(
  parameter int PIPELINE_COUNT = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 24
);
  logic [PIPELINE_COUNT-1:0]                 req;
  logic [PIPELINE_COUNT-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [PIPELINE_COUNT-1:0]                 grant;
  logic                                      rom_en;
  logic [ADDR_WIDTH-1:0]                     rom_addr;
  logic [DATA_WIDTH-1:0]                     rom_data;
  logic [PIPELINE_COUNT-1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]                     rsp_data;

  modport slave (
    input  req, req_addr, rom_data,
    output grant, rom_en, rom_addr,
    output rsp_valid, rsp_data
  );

  modport master (
    output req, req_addr, rom_data,
    input  grant, rom_en, rom_addr,
    input  rsp_valid, rsp_data
  );
endinterface

// File: rtl/wavetable_arbiter.sv
// Round-robin share of one wavetable ROM read port among pipelines.
// Ports: clock_50_000_000, reset (sync, active-high), bus (slave):
//   req/req_addr in, grant out (comb), rom_en/rom_addr out (reg),
//   rom_data in, rsp_valid/rsp_data out (reg).
// Option WAVETABLE_ARBITER_STATS_EN adds stat_grants, stat_contention.
module wavetable_arbiter #(
  parameter int PIPELINE_COUNT = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 24,
  parameter int ROM_LATENCY    = 2
) (
  input  logic clock_50_000_000,
  input  logic reset,
`ifdef WAVETABLE_ARBITER_STATS_EN
  output logic [31:0] stat_grants,
  output logic [15:0] stat_contention,
`endif
  wavetable_arbiter_if.slave bus
);
  localparam int PW   = $clog2(PIPELINE_COUNT);
  localparam int TAGS = ROM_LATENCY + 1;
  localparam logic [PW-1:0] LAST = PW'(PIPELINE_COUNT - 1);

  typedef logic [PIPELINE_COUNT-1:0] vec_t;

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         k_d;
  logic                  hit_d;
  vec_t                  grant_d;
  logic                  rom_en_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  vec_t [TAGS-1:0]       tag_q;
  vec_t                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  // Rotating priority search starting at ptr_q.
  always_comb begin : arb
    int j;
    j       = 0;
    k_d     = ptr_q;
    hit_d   = 1'b0;
    grant_d = '0;
    ptr_d   = ptr_q;
    for (int i = 0; i < PIPELINE_COUNT; i++) begin
      j = int'(ptr_q) + i;
      if (j >= PIPELINE_COUNT) j = j - PIPELINE_COUNT;
      if (!hit_d && bus.req[j]) begin
        hit_d = 1'b1;
        k_d   = PW'(j);
      end
    end
    if (reset) hit_d = 1'b0;
    if (hit_d) begin
      grant_d[k_d] = 1'b1;
      ptr_d = (k_d == LAST) ? '0 : k_d + PW'(1);
    end
  end

  assign bus.grant     = grant_d;
  assign bus.rom_en    = rom_en_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // tag_q[0] lines up with rom_en; the last stage lines up with
  // valid rom_data, which is captured into the response register.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      ptr_q       <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rom_en_q <= hit_d;
      if (hit_d) rom_addr_q <= bus.req_addr[k_d];
      tag_q[0] <= grant_d;
      for (int i = 1; i < TAGS; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      rsp_valid_q <= tag_q[TAGS-1];
      if (|tag_q[TAGS-1]) rsp_data_q <= bus.rom_data;
    end
  end

`ifdef WAVETABLE_ARBITER_STATS_EN
  logic [31:0] grants_q;
  logic [15:0] cont_q;
  vec_t        req_m1;
  logic        multi;

  // Clearing the lowest set bit leaves a residue iff >=2 bits set.
  assign req_m1 = bus.req - vec_t'(1);
  assign multi  = |(bus.req & req_m1);

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      grants_q <= '0;
      cont_q   <= '0;
    end else begin
      if (hit_d) grants_q <= grants_q + 32'd1;
      if (multi && cont_q != 16'hFFFF) begin
        cont_q <= cont_q + 16'd1;
      end
    end
  end

  assign stat_grants     = grants_q;
  assign stat_contention = cont_q;
`endif
endmodule

// File: tb/tb_wavetable_arbiter.sv
// Self-checking bench for wavetable_arbiter.
// Bench acts as the pipelines and as the ROM.
module tb_wavetable_arbiter;
  localparam int N  = 8;
  localparam int AW = 12;
  localparam int DW = 24;
  localparam int L  = 2;
  localparam int SZ = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  wavetable_arbiter_if #(
    .PIPELINE_COUNT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

`ifdef WAVETABLE_ARBITER_STATS_EN
  logic [31:0] stat_grants;
  logic [15:0] stat_contention;
`endif

  wavetable_arbiter #(
    .PIPELINE_COUNT(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .ROM_LATENCY(L)
  ) dut (
    .clock_50_000_000(clk),
    .reset(rst),
`ifdef WAVETABLE_ARBITER_STATS_EN
    .stat_grants(stat_grants),
    .stat_contention(stat_contention),
`endif
    .bus(bus)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    if (a == 12'h123) return 24'hABCDEF;
    return {a, a ^ 12'h5A5};
  endfunction

  // ROM: reads every cycle, data L cycles after the address.
  logic [DW-1:0] romq [L];
  always @(posedge clk) begin
    romq[0] <= rom_f(bus.rom_addr);
    for (int i = 1; i < L; i++) romq[i] <= romq[i-1];
  end
  assign bus.rom_data = romq[L-1];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: expectations scheduled by absolute cycle.
  bit            en_s [SZ];
  logic [AW-1:0] ad_s [SZ];
  logic [N-1:0]  rv_s [SZ];
  logic [DW-1:0] rd_s [SZ];
  int            mptr     = 0;
  bit            rst_prev = 1'b1;
  logic [AW-1:0] addr_cur = '0;
  logic [DW-1:0] rd_cur   = '0;

  initial begin
    for (int i = 0; i < SZ; i++) begin
      en_s[i] = 1'b0;
      ad_s[i] = '0;
      rv_s[i] = '0;
      rd_s[i] = '0;
    end
  end

  initial begin : compare
    int c;
    int k;
    logic [N-1:0] eg;
    c = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (c + L + 4 >= SZ) begin
        $display("FAIL model_overflow cycle=%0d", c);
        $fatal(1);
      end
      if (rst_prev) begin
        addr_cur = '0;
        rd_cur   = '0;
      end
      if (en_s[c]) addr_cur = ad_s[c];
      if (rv_s[c] != 0) rd_cur = rd_s[c];
      eg = '0;
      k  = -1;
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          if (k < 0 && bus.req[(mptr + i) % N]) begin
            k = (mptr + i) % N;
          end
        end
        if (k >= 0) eg[k] = 1'b1;
      end
      chk("m_grant", 64'(bus.grant), 64'(eg));
      chk("m_rom_en", 64'(bus.rom_en), 64'(en_s[c]));
      chk("m_rom_addr", 64'(bus.rom_addr), 64'(addr_cur));
      chk("m_rsp_valid", 64'(bus.rsp_valid), 64'(rv_s[c]));
      chk("m_rsp_data", 64'(bus.rsp_data), 64'(rd_cur));
      if (rst) begin
        for (int i = c + 1; i < c + L + 4; i++) begin
          en_s[i] = 1'b0;
          rv_s[i] = '0;
        end
        mptr = 0;
      end else if (k >= 0) begin
        en_s[c+1]   = 1'b1;
        ad_s[c+1]   = bus.req_addr[k];
        rv_s[c+2+L] = eg;
        rd_s[c+2+L] = rom_f(bus.req_addr[k]);
        mptr = (k + 1) % N;
      end
      rst_prev = rst;
      c++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.req = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : stim
    int cnt [N];
    int en_cnt;
    int g1;
    bus.req      = '0;
    bus.req_addr = '0;
    step();
    step();
    rst = 1'b0;
    step();

    // single read by pipeline 3
    bus.req_addr[3] = 12'h123;
    bus.req = 8'h08;
    @(negedge clk);
    chk("t1_grant", 64'(bus.grant), 64'h08);
    step();
    bus.req = '0;
    @(negedge clk);
    chk("t1_rom_en", 64'(bus.rom_en), 64'h1);
    chk("t1_rom_addr", 64'(bus.rom_addr), 64'h123);
    step();
    @(negedge clk);
    chk("t1_rv_c2", 64'(bus.rsp_valid), 64'h0);
    step();
    @(negedge clk);
    chk("t1_rv_c3", 64'(bus.rsp_valid), 64'h0);
    step();
    @(negedge clk);
    chk("t1_rv_c4", 64'(bus.rsp_valid), 64'h08);
    chk("t1_rd_c4", 64'(bus.rsp_data), 64'hABCDEF);
    step();
    @(negedge clk);
    chk("t1_rv_c5", 64'(bus.rsp_valid), 64'h0);
    chk("t1_rd_hold", 64'(bus.rsp_data), 64'hABCDEF);
    idle(2);

    // full load from reset
    do_reset();
    for (int p = 0; p < N; p++) begin
      bus.req_addr[p] = AW'(12'h200 + p);
      cnt[p] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      bus.req = 8'hFF;
      @(negedge clk);
      chk("t2_grant", 64'(bus.grant), 64'(1) << (i % N));
      for (int p = 0; p < N; p++) begin
        if (bus.grant[p]) cnt[p]++;
      end
      step();
    end
    for (int p = 0; p < N; p++) begin
      chk("t2_count", 64'(cnt[p]), 64'd2);
    end
    idle(6);

    // sparse round-robin
    do_reset();
    bus.req = 8'h24;
    @(negedge clk);
    chk("t3_g0", 64'(bus.grant), 64'h04);
    step();
    @(negedge clk);
    chk("t3_g1", 64'(bus.grant), 64'h20);
    step();
    @(negedge clk);
    chk("t3_g2", 64'(bus.grant), 64'h04);
    step();
    @(negedge clk);
    chk("t3_g3", 64'(bus.grant), 64'h20);
    step();
    idle(6);

    // withdraw before turn
    do_reset();
    bus.req = 8'h03;
    @(negedge clk);
    chk("t4_grant", 64'(bus.grant), 64'h01);
    step();
    bus.req = '0;
    en_cnt = 0;
    g1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rom_en) en_cnt++;
      if (bus.grant[1]) g1++;
      step();
    end
    chk("t4_rom_en_pulses", 64'(en_cnt), 64'd1);
    chk("t4_grant1", 64'(g1), 64'd0);

    // reset mid-flight
    do_reset();
    bus.req_addr[6] = 12'h066;
    bus.req = 8'h40;
    @(negedge clk);
    chk("t5_grant", 64'(bus.grant), 64'h40);
    step();
    bus.req = '0;
    @(negedge clk);
    chk("t5_rv_c1", 64'(bus.rsp_valid), 64'h0);
    step();
    rst = 1'b1;
    bus.req = 8'h01;
    @(negedge clk);
    chk("t5_rst_grant", 64'(bus.grant), 64'h0);
    step();
    rst = 1'b0;
    bus.req = '0;
    for (int i = 3; i <= 8; i++) begin
      @(negedge clk);
      chk("t5_rv_quiet", 64'(bus.rsp_valid), 64'h0);
      step();
    end
    bus.req = 8'hFF;
    @(negedge clk);
    chk("t5_ptr0", 64'(bus.grant), 64'h01);
    step();
    idle(6);

    // back-to-back reads by one pipeline
    bus.req_addr[3] = 12'h3C3;
    bus.req = 8'h08;
    step();
    step();
    step();
    idle(6);

    // pseudo-random traffic, addresses stable
    for (int p = 0; p < N; p++) begin
      bus.req_addr[p] = AW'($urandom);
    end
    for (int i = 0; i < 60; i++) begin
      bus.req = N'($urandom);
      step();
    end
    idle(8);

`ifdef WAVETABLE_ARBITER_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.req = 8'h03;
      step();
    end
    bus.req = '0;
    @(negedge clk);
    chk("t6_grants", 64'(stat_grants), 64'd10);
    chk("t6_cont", 64'(stat_contention), 64'd10);
    step();
    do_reset();
    @(negedge clk);
    chk("t6_grants_rst", 64'(stat_grants), 64'd0);
    chk("t6_cont_rst", 64'(stat_contention), 64'd0);
    idle(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
